// File: rtl/llc_output_encoder_pkg.sv
// llc_output_encoder_pkg: message structs and slot state shared by the LLC output encoder.
package llc_output_encoder_pkg;

    typedef logic [2:0]  coh_msg_t;
    typedef logic [27:0] line_addr_t;
    typedef logic [63:0] line_t;
    typedef logic [3:0]  cache_id_t;

    typedef struct packed {
        coh_msg_t   coh_msg;
        line_addr_t addr;
        line_t      line;
        cache_id_t  req_id;
    } llc_rsp_out_t;

    typedef struct packed {
        coh_msg_t   coh_msg;
        line_addr_t addr;
        cache_id_t  req_id;
        cache_id_t  dest_id;
    } llc_fwd_out_t;

    typedef struct packed {
        logic       hwrite;
        line_addr_t addr;
        line_t      line;
    } llc_mem_req_t;

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;

endpackage

// File: rtl/llc_out_slot.sv
// llc_out_slot: one-entry EMPTY/FULL output register; the owner only loads when not blocked.
module llc_out_slot
    import llc_output_encoder_pkg::*;
#(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic ready,
    input  T     din,
    output logic valid,
    output logic blocked,
    output T     dout
);

    slot_state_t state_q, state_d;
    T            data_q, data_d;

    // a load wins over a same-cycle fire so back-to-back sends keep the slot FULL
    always_comb begin
        state_d = load ? SLOT_FULL : ((state_q == SLOT_FULL) && ready) ? SLOT_EMPTY : state_q;
        data_d  = load ? din : data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign valid   = state_q == SLOT_FULL;
    assign blocked = valid && !ready;
    assign dout    = data_q;

endmodule

// File: rtl/llc_output_encoder.sv
// llc_output_encoder: registers LLC FSM sends onto four valid/ready channels with all-or-nothing stall.
// Optional per-channel sent counters under LLC_OUT_STATS_EN.
module llc_output_encoder
    import llc_output_encoder_pkg::*;
#(
    parameter int STATS_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               encode_en,
    input  logic               send_rsp_out,
    input  logic               send_fwd_out,
    input  logic               send_mem_req,
    input  logic               send_rst_tb_done,
    input  llc_rsp_out_t       rsp_out_in,
    input  llc_fwd_out_t       fwd_out_in,
    input  llc_mem_req_t       mem_req_in,
    output logic               encode_stall,
    output logic               llc_rsp_out_valid_int,
    output logic               llc_fwd_out_valid_int,
    output logic               llc_mem_req_valid_int,
    output logic               llc_rst_tb_done_valid_int,
    input  logic               llc_rsp_out_ready_int,
    input  logic               llc_fwd_out_ready_int,
    input  logic               llc_mem_req_ready_int,
    input  logic               llc_rst_tb_done_ready_int,
    output llc_rsp_out_t       llc_rsp_out,
    output llc_fwd_out_t       llc_fwd_out,
    output llc_mem_req_t       llc_mem_req,
    output logic               llc_rst_tb_done_o,
    output logic [STATS_W-1:0] stat_rsp_cnt,
    output logic [STATS_W-1:0] stat_fwd_cnt,
    output logic [STATS_W-1:0] stat_mem_cnt
);

    logic rsp_blk, fwd_blk, mem_blk, done_blk, accept, done_flag;

    // gated by rst so the FSM never sees a stall while the channels are being cleared
    assign encode_stall = rst && encode_en &&
        ((send_rsp_out && rsp_blk) || (send_fwd_out && fwd_blk) ||
         (send_mem_req && mem_blk) || (send_rst_tb_done && done_blk));
    assign accept = encode_en && !encode_stall;

    llc_out_slot #(.T(llc_rsp_out_t)) u_rsp (
        .clk(clk), .rst(rst), .load(accept && send_rsp_out), .ready(llc_rsp_out_ready_int),
        .din(rsp_out_in), .valid(llc_rsp_out_valid_int), .blocked(rsp_blk), .dout(llc_rsp_out)
    );

    llc_out_slot #(.T(llc_fwd_out_t)) u_fwd (
        .clk(clk), .rst(rst), .load(accept && send_fwd_out), .ready(llc_fwd_out_ready_int),
        .din(fwd_out_in), .valid(llc_fwd_out_valid_int), .blocked(fwd_blk), .dout(llc_fwd_out)
    );

    llc_out_slot #(.T(llc_mem_req_t)) u_mem (
        .clk(clk), .rst(rst), .load(accept && send_mem_req), .ready(llc_mem_req_ready_int),
        .din(mem_req_in), .valid(llc_mem_req_valid_int), .blocked(mem_blk), .dout(llc_mem_req)
    );

    // the done channel has no payload; its stored bit is always 1 once loaded
    llc_out_slot #(.T(logic)) u_done (
        .clk(clk), .rst(rst), .load(accept && send_rst_tb_done), .ready(llc_rst_tb_done_ready_int),
        .din(1'b1), .valid(llc_rst_tb_done_valid_int), .blocked(done_blk), .dout(done_flag)
    );

    assign llc_rst_tb_done_o = llc_rst_tb_done_valid_int && done_flag;

`ifdef LLC_OUT_STATS_EN
    logic [STATS_W-1:0] rsp_cnt_q, rsp_cnt_d, fwd_cnt_q, fwd_cnt_d, mem_cnt_q, mem_cnt_d;

    always_comb begin
        rsp_cnt_d = (llc_rsp_out_valid_int && llc_rsp_out_ready_int && !(&rsp_cnt_q)) ? rsp_cnt_q + STATS_W'(1) : rsp_cnt_q;
        fwd_cnt_d = (llc_fwd_out_valid_int && llc_fwd_out_ready_int && !(&fwd_cnt_q)) ? fwd_cnt_q + STATS_W'(1) : fwd_cnt_q;
        mem_cnt_d = (llc_mem_req_valid_int && llc_mem_req_ready_int && !(&mem_cnt_q)) ? mem_cnt_q + STATS_W'(1) : mem_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_cnt_q <= '0;
            fwd_cnt_q <= '0;
            mem_cnt_q <= '0;
        end else begin
            rsp_cnt_q <= rsp_cnt_d;
            fwd_cnt_q <= fwd_cnt_d;
            mem_cnt_q <= mem_cnt_d;
        end
    end

    assign stat_rsp_cnt = rsp_cnt_q;
    assign stat_fwd_cnt = fwd_cnt_q;
    assign stat_mem_cnt = mem_cnt_q;
`else
    assign stat_rsp_cnt = '0;
    assign stat_fwd_cnt = '0;
    assign stat_mem_cnt = '0;
`endif

endmodule

// File: tb/tb_llc_output_encoder.sv
// tb_llc_output_encoder: directed and random checks of the output encoder against a queue-based model.
module tb_llc_output_encoder;
    import llc_output_encoder_pkg::*;

    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst, encode_en, send_rsp_out, send_fwd_out, send_mem_req, send_rst_tb_done;
    logic rdy_rsp, rdy_fwd, rdy_mem, rdy_done;
    llc_rsp_out_t rsp_out_in, llc_rsp_out;
    llc_fwd_out_t fwd_out_in, llc_fwd_out;
    llc_mem_req_t mem_req_in, llc_mem_req;
    logic encode_stall, v_rsp, v_fwd, v_mem, v_done, done_o;
    logic [SW-1:0] c_rsp, c_fwd, c_mem;

    int total = 0;
    int bad = 0;

    llc_rsp_out_t rsp_q[$];
    llc_fwd_out_t fwd_q[$];
    llc_mem_req_t mem_q[$];
    bit           done_q[$];
    int n_rsp, n_fwd, n_mem;

    always #5 clk = ~clk;

    llc_output_encoder #(.STATS_W(SW)) dut (
        .clk(clk), .rst(rst), .encode_en(encode_en),
        .send_rsp_out(send_rsp_out), .send_fwd_out(send_fwd_out),
        .send_mem_req(send_mem_req), .send_rst_tb_done(send_rst_tb_done),
        .rsp_out_in(rsp_out_in), .fwd_out_in(fwd_out_in), .mem_req_in(mem_req_in),
        .encode_stall(encode_stall),
        .llc_rsp_out_valid_int(v_rsp), .llc_fwd_out_valid_int(v_fwd),
        .llc_mem_req_valid_int(v_mem), .llc_rst_tb_done_valid_int(v_done),
        .llc_rsp_out_ready_int(rdy_rsp), .llc_fwd_out_ready_int(rdy_fwd),
        .llc_mem_req_ready_int(rdy_mem), .llc_rst_tb_done_ready_int(rdy_done),
        .llc_rsp_out(llc_rsp_out), .llc_fwd_out(llc_fwd_out), .llc_mem_req(llc_mem_req),
        .llc_rst_tb_done_o(done_o),
        .stat_rsp_cnt(c_rsp), .stat_fwd_cnt(c_fwd), .stat_mem_cnt(c_mem)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt(input int n);
`ifdef LLC_OUT_STATS_EN
        return n > 3 ? 3 : n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic rand_payload();
        rsp_out_in.coh_msg = 3'($urandom);
        rsp_out_in.addr    = 28'($urandom);
        rsp_out_in.line    = {$urandom, $urandom};
        rsp_out_in.req_id  = 4'($urandom);
        fwd_out_in.coh_msg = 3'($urandom);
        fwd_out_in.addr    = 28'($urandom);
        fwd_out_in.req_id  = 4'($urandom);
        fwd_out_in.dest_id = 4'($urandom);
        mem_req_in.hwrite  = 1'($urandom);
        mem_req_in.addr    = 28'($urandom);
        mem_req_in.line    = {$urandom, $urandom};
    endtask

    task automatic check_outputs();
        chk("rsp_valid", 128'(v_rsp), 128'(rsp_q.size() != 0));
        chk("fwd_valid", 128'(v_fwd), 128'(fwd_q.size() != 0));
        chk("mem_valid", 128'(v_mem), 128'(mem_q.size() != 0));
        chk("done_valid", 128'(v_done), 128'(done_q.size() != 0));
        chk("done_o", 128'(done_o), 128'(done_q.size() != 0));
        if (rsp_q.size() != 0) chk("rsp_payload", 128'(llc_rsp_out), 128'(rsp_q[0]));
        if (fwd_q.size() != 0) chk("fwd_payload", 128'(llc_fwd_out), 128'(fwd_q[0]));
        if (mem_q.size() != 0) chk("mem_payload", 128'(llc_mem_req), 128'(mem_q[0]));
        chk("rsp_cnt", 128'(c_rsp), 128'(exp_cnt(n_rsp)));
        chk("fwd_cnt", 128'(c_fwd), 128'(exp_cnt(n_fwd)));
        chk("mem_cnt", 128'(c_mem), 128'(exp_cnt(n_mem)));
    endtask

    // one clock with rst high: checks stall before the edge, then the registered outputs after it
    task automatic cyc(input bit en, input bit sr, input bit sf, input bit sm, input bit sd,
                       input bit rr, input bit rf, input bit rm, input bit rd);
        bit stall_m;
        encode_en = en; send_rsp_out = sr; send_fwd_out = sf; send_mem_req = sm; send_rst_tb_done = sd;
        rdy_rsp = rr; rdy_fwd = rf; rdy_mem = rm; rdy_done = rd;
        #1;
        stall_m = en && ((sr && rsp_q.size() != 0 && !rr) || (sf && fwd_q.size() != 0 && !rf) ||
                         (sm && mem_q.size() != 0 && !rm) || (sd && done_q.size() != 0 && !rd));
        chk("stall", 128'(encode_stall), 128'(stall_m));
        @(posedge clk);
        if (rsp_q.size() != 0 && rr) begin rsp_q.delete(0); n_rsp++; end
        if (fwd_q.size() != 0 && rf) begin fwd_q.delete(0); n_fwd++; end
        if (mem_q.size() != 0 && rm) begin mem_q.delete(0); n_mem++; end
        if (done_q.size() != 0 && rd) done_q.delete(0);
        if (en && !stall_m) begin
            if (sr) rsp_q.push_back(rsp_out_in);
            if (sf) fwd_q.push_back(fwd_out_in);
            if (sm) mem_q.push_back(mem_req_in);
            if (sd) done_q.push_back(1'b1);
        end
        #1;
        check_outputs();
    endtask

    task automatic rst_cyc();
        rst = 1'b0;
        #1;
        chk("stall_in_reset", 128'(encode_stall), 128'(0));
        @(posedge clk);
        rsp_q.delete(); fwd_q.delete(); mem_q.delete(); done_q.delete();
        n_rsp = 0; n_fwd = 0; n_mem = 0;
        #1;
        check_outputs();
        chk("rsp_zero", 128'(llc_rsp_out), 128'(0));
        chk("fwd_zero", 128'(llc_fwd_out), 128'(0));
        chk("mem_zero", 128'(llc_mem_req), 128'(0));
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; encode_en = 1'b0;
        send_rsp_out = 1'b0; send_fwd_out = 1'b0; send_mem_req = 1'b0; send_rst_tb_done = 1'b0;
        rdy_rsp = 1'b0; rdy_fwd = 1'b0; rdy_mem = 1'b0; rdy_done = 1'b0;
        rsp_out_in = '0; fwd_out_in = '0; mem_req_in = '0;
        @(posedge clk);
        #1;
        rst_cyc();

        rand_payload();
        rsp_out_in.addr = 28'h1234;
        cyc(1, 1, 0, 0, 0, 1, 1, 1, 1);
        chk("rsp_addr_1234", 128'(llc_rsp_out.addr), 128'h1234);
        cyc(1, 0, 0, 0, 0, 1, 1, 1, 1);
        chk("rsp_empty_after_fire", 128'(v_rsp), 128'(0));

        rand_payload();
        cyc(1, 0, 0, 1, 0, 1, 1, 0, 1);
        rand_payload();
        cyc(1, 0, 1, 1, 0, 1, 1, 0, 1);
        chk("fwd_stays_empty", 128'(v_fwd), 128'(0));
        cyc(1, 0, 1, 1, 0, 1, 0, 1, 1);
        chk("fwd_loaded", 128'(v_fwd), 128'(1));
        cyc(1, 0, 0, 0, 0, 1, 1, 1, 1);

        rand_payload();
        cyc(1, 1, 0, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            rand_payload();
            cyc(1, i == 2, 0, 0, 0, 0, 1, 1, 1);
        end
        cyc(1, 0, 0, 0, 0, 1, 1, 1, 1);

        rst_cyc();
        for (int i = 0; i < 4; i++) begin
            rand_payload();
            cyc(1, 1, 0, 0, 0, 1, 1, 1, 1);
        end
        cyc(1, 0, 0, 0, 0, 1, 1, 1, 1);
        cyc(1, 0, 0, 0, 0, 1, 1, 1, 1);

        cyc(0, 0, 0, 0, 1, 1, 1, 1, 1);
        chk("done_ignored", 128'(v_done), 128'(0));
        cyc(1, 0, 0, 0, 1, 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 1, 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 1);

        for (int i = 0; i < 300; i++) begin
            rand_payload();
            cyc($urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
        end

        rand_payload();
        cyc(1, 0, 1, 0, 0, 1, 0, 1, 1);
        chk("fwd_full_before_reset", 128'(v_fwd), 128'(1));
        send_fwd_out = 1'b1; encode_en = 1'b1; rdy_fwd = 1'b0;
        rst_cyc();
        chk("fwd_invalid_after_reset", 128'(v_fwd), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
